xpu_vpu_pc_tn_vlsu_ld_elem_seq: RTL
===================================

Name: xpu_vpu_pc_tn_vlsu_ld_elem_seq

Overview:
- Downstream consumer of the VLSU load uop decode stage.
- Captures one decoded load uop per handshake into a holding register, then walks its elements from vstart_len up to ele_len.
- Skips masked-off elements and emits one element request per cycle: element index, zero-extended index offset, uid. Feeds the VLSU load address generator.
- Signals uop completion with a one-cycle completion pulse.

Parameters:
- UID_W, 8, uop id width
- VLEN, 128, lane vector register width in bits
- ENUM, 16, max elements per uop (VLEN/8)

Ports:
- vpu_clk  in  1  clock
- vpu_rst  in  1  synchronous active-high reset
- ld_uop_vld  in  1  decoded load uop valid
- ld_uop_rdy  out  1  sequencer can accept a uop
- ld_uop_uid  in  UID_W  uop id
- ld_uop_eew  in  2  index element width: 0=8b, 1=16b, 2=32b, 3=64b
- ld_uop_vm  in  1  1 = unmasked, all elements active
- ld_uop_vidx_data  in  VLEN  index register data
- ld_uop_vidx_start  in  4  index slot of element 0
- ld_uop_vmask_data  in  ENUM  mask bits
- ld_uop_vmask_start  in  4  mask bit of element 0
- ld_uop_ele_len  in  5  end element count, 0..16
- ld_uop_vstart_len  in  5  first element index, 0..16
- ld_uop_op_last  in  1  last uop of the instruction
- flush  in  1  synchronous kill of the in-flight uop
- elem_vld  out  1  element request valid
- elem_rdy  in  1  downstream accepts the element
- elem_uid  out  UID_W  uid of the owning uop
- elem_idx  out  4  element number i
- elem_offset  out  64  zero-extended index field of element i
- elem_last  out  1  no further active element follows in this uop
- cmplt_vld  out  1  one-cycle uop completion pulse
- cmplt_uid  out  UID_W  completed uid
- cmplt_op_last  out  1  registered op_last

Behaviour:
Reset and handshake:
- Reset: state=IDLE, cnt=0, all outputs 0 except ld_uop_rdy=1. All held fields are cleared to 0.
- ld_uop_rdy = (state==IDLE) & ~flush.
- A uop is accepted on ld_uop_vld & ld_uop_rdy. All fields are registered; cnt <= vstart_len; state <= SEQ on the next cycle.

States:
- IDLE: wait for a uop.
- SEQ:
  - If cnt >= ele_len, go to CMPLT with no element emitted. This covers vstart_len >= ele_len and ele_len=0.
  - Otherwise act(cnt) = vm | vmask_data[(vmask_start+cnt) mod 16].
  - If act: elem_vld=1, combinational from the registered state. On elem_rdy, cnt <= cnt+1. Without elem_rdy, all elem_* outputs hold stable.
  - If not act: elem_vld=0 and cnt <= cnt+1, skipping one element per cycle.
- CMPLT: cmplt_vld=1 for exactly one cycle with cmplt_uid and cmplt_op_last; then go to IDLE. A new uop can be accepted in the cycle after CMPLT, never in the same cycle.

Index extraction:
- slot = (vidx_start + cnt) mod (16>>eew).
- elem_offset = zero-extend(vidx_data[slot*(8<<eew) +: (8<<eew)]).
- Example: eew=2, slot 3 gives bits [127:96].

Last-element flag:
- elem_last=1 when no j with cnt < j < ele_len has act(j)=1.
- Computed from a masked bit-vector of the remaining elements, not by iteration.

Width rules and illegal inputs:
- ele_len > (16>>eew) is illegal. The sequencer still walks with slot wrap-around and does not hang.
- cnt is 5 bits, so cnt=16 compares correctly against ele_len=16.

Flush:
- flush in any state: state <= IDLE, elem_vld=0 that cycle, no cmplt pulse.
- A uop presented in the same cycle as flush is not accepted.
- flush has priority over elem_rdy and over reaching CMPLT.

Reset mid-operation: same as flush, plus all registers are cleared.

Latency:
- First element request: 1 cycle after uop accept, when element vstart_len is active.
- Fully unmasked uop of N elements with elem_rdy tied high: cmplt_vld 1 + N cycles after accept.

Test Plan:
- Unmasked, eew=0, vstart=0, ele_len=16, elem_rdy=1, vidx_data byte k = k+1 -> 16 consecutive elem_vld with idx 0..15 and offset 1..16; elem_last only on idx 15; cmplt_vld on cycle 17 after accept.
- vm=0, vmask_data=16'h0005, eew=1, ele_len=8, vidx_start=0 -> only idx 0 and 2 emitted; offsets = halfwords 0 and 2; elem_last on idx 2; cmplt after the walk completes.
- eew=3, vidx_start=1, ele_len=2, vidx_data={64'hA,64'hB} (A in the upper 64 bits) -> idx0 offset 0xA, idx1 offset 0xB; eew=2, vidx_start=3, ele_len=2 -> idx0 uses bits [127:96], idx1 wraps to bits [31:0].
- vstart_len=4, ele_len=4 (also ele_len=0) -> no elem_vld; cmplt_vld 2 cycles after accept; uid and op_last echoed.
- elem_rdy held low 3 cycles at idx 5 -> elem_vld, idx, offset and uid stable for those 3 cycles; advances only after elem_rdy rises.
- flush asserted while elem_vld=1 at idx 7, and vpu_rst asserted mid-walk -> next cycle IDLE, ld_uop_rdy=1, no cmplt_vld; the next uop starts cleanly from its own vstart_len.

Source files
------------

// File: rtl/xpu_vpu_pc_tn_vlsu_ld_elem_seq.sv
// VLSU load element sequencer.
// Holds one decoded load uop and walks its elements from vstart_len up to
// ele_len. Masked-off elements are skipped at one per cycle. Each active
// element is presented as a request (index, zero-extended index field, uid)
// until it is accepted. Accepting the last active element moves straight to
// the completion cycle, so an unmasked N-element uop completes 1+N cycles
// after it was accepted.
module xpu_vpu_pc_tn_vlsu_ld_elem_seq #(
   parameter int UID_W = 8,
   parameter int VLEN  = 128,
   parameter int ENUM  = 16
) (
   input  logic             vpu_clk,
   input  logic             vpu_rst,
   input  logic             ld_uop_vld,
   output logic             ld_uop_rdy,
   input  logic [UID_W-1:0] ld_uop_uid,
   input  logic [1:0]       ld_uop_eew,
   input  logic             ld_uop_vm,
   input  logic [VLEN-1:0]  ld_uop_vidx_data,
   input  logic [3:0]       ld_uop_vidx_start,
   input  logic [ENUM-1:0]  ld_uop_vmask_data,
   input  logic [3:0]       ld_uop_vmask_start,
   input  logic [4:0]       ld_uop_ele_len,
   input  logic [4:0]       ld_uop_vstart_len,
   input  logic             ld_uop_op_last,
   input  logic             flush,
   output logic             elem_vld,
   input  logic             elem_rdy,
   output logic [UID_W-1:0] elem_uid,
   output logic [3:0]       elem_idx,
   output logic [63:0]      elem_offset,
   output logic             elem_last,
   output logic             cmplt_vld,
   output logic [UID_W-1:0] cmplt_uid,
   output logic             cmplt_op_last
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEQ   = 2'd1,
      CMPLT = 2'd2
   } state_e;

   state_e             state_q;
   logic [4:0]         cnt_q;
   logic [UID_W-1:0]   uid_q;
   logic [1:0]         eew_q;
   logic               vm_q;
   logic [VLEN-1:0]    vidx_q;
   logic [3:0]         vidx_start_q;
   logic [ENUM-1:0]    vmask_q;
   logic [3:0]         vmask_start_q;
   logic [4:0]         ele_len_q;
   logic               op_last_q;

   logic [15:0]        act_vec;
   logic [15:0]        gt_mask;
   logic [15:0]        lt_mask;
   logic [15:0]        rem_vec;
   logic               in_rng;
   logic               act_cur;
   logic               kill;
   logic [4:0]         cnt_d;
   logic [3:0]         slot_sum;

   // Per-element activity, relative to element 0 of the uop.
   always_comb begin
      act_vec = '0;
      for (int j = 0; j < 16; j++) begin
         act_vec[j] = vm_q | vmask_q[4'(vmask_start_q + 4'(j))];
      end
   end

   // Remaining-element window (cnt, ele_len) and derived control terms.
   always_comb begin
      gt_mask  = 16'hFFFF << (cnt_q + 5'd1);
      lt_mask  = ~(16'hFFFF << ele_len_q);
      rem_vec  = act_vec & gt_mask & lt_mask;
      in_rng   = (cnt_q < ele_len_q);
      act_cur  = act_vec[cnt_q[3:0]];
      kill     = flush | vpu_rst;
      cnt_d    = cnt_q + 5'd1;
      // Slot count is a power of two dividing 16, so mod 16 first is exact.
      slot_sum = vidx_start_q + cnt_q[3:0];
   end

   // Index field extraction: low slot bits select the field for each width.
   always_comb begin
      elem_offset = '0;
      unique case (eew_q)
         2'd0: elem_offset = {56'd0, vidx_q[{slot_sum[3:0], 3'b000} +: 8]};
         2'd1: elem_offset = {48'd0, vidx_q[{slot_sum[2:0], 4'b0000} +: 16]};
         2'd2: elem_offset = {32'd0, vidx_q[{slot_sum[1:0], 5'b00000} +: 32]};
         default: elem_offset = vidx_q[{slot_sum[0], 6'b000000} +: 64];
      endcase
   end

   // Request and completion outputs, suppressed in a kill cycle.
   always_comb begin
      ld_uop_rdy    = (state_q == IDLE) & ~flush;
      elem_vld      = (state_q == SEQ) & in_rng & act_cur & ~kill;
      elem_last     = (state_q == SEQ) & ~(|rem_vec);
      elem_uid      = uid_q;
      elem_idx      = cnt_q[3:0];
      cmplt_vld     = (state_q == CMPLT) & ~kill;
      cmplt_uid     = uid_q;
      cmplt_op_last = op_last_q;
   end

   // Sequencer FSM with the uop holding register.
   always_ff @(posedge vpu_clk) begin
      if (vpu_rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         uid_q         <= '0;
         eew_q         <= '0;
         vm_q          <= 1'b0;
         vidx_q        <= '0;
         vidx_start_q  <= '0;
         vmask_q       <= '0;
         vmask_start_q <= '0;
         ele_len_q     <= '0;
         op_last_q     <= 1'b0;
      end else if (flush) begin
         state_q <= IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ld_uop_vld) begin
                  state_q       <= SEQ;
                  cnt_q         <= ld_uop_vstart_len;
                  uid_q         <= ld_uop_uid;
                  eew_q         <= ld_uop_eew;
                  vm_q          <= ld_uop_vm;
                  vidx_q        <= ld_uop_vidx_data;
                  vidx_start_q  <= ld_uop_vidx_start;
                  vmask_q       <= ld_uop_vmask_data;
                  vmask_start_q <= ld_uop_vmask_start;
                  ele_len_q     <= ld_uop_ele_len;
                  op_last_q     <= ld_uop_op_last;
               end
            end
            SEQ: begin
               if (!in_rng) begin
                  state_q <= CMPLT;
               end else if (!act_cur) begin
                  cnt_q <= cnt_d;
               end else if (elem_rdy) begin
                  cnt_q <= cnt_d;
                  if (elem_last) state_q <= CMPLT;
               end
            end
            CMPLT: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
